// File: rtl/ex_alu_uart_ctrl.sv
// UART byte-stream front end for the EX-stage ALU: assembles op1/op2/code, captures the result, serialises it back.
// Result's first o_tx_start two cycles after the opcode byte; rx bytes are dropped while o_busy, next tx byte waits on i_tx_done.
module ex_alu_uart_ctrl #(
  parameter int NB_DATA = 32,
  parameter int NB_OP   = 6,
  parameter int NB_BYTE = 8
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic [NB_BYTE-1:0] i_rx_data,
  input  logic               i_rx_valid,
  input  logic               i_tx_done,
  output logic [NB_BYTE-1:0] o_tx_data,
  output logic               o_tx_start,
  output logic [NB_DATA-1:0] o_alu_data_1,
  output logic [NB_DATA-1:0] o_alu_data_2,
  output logic [NB_OP-1:0]   o_alu_code,
  input  logic [NB_DATA-1:0] i_alu_result,
  output logic               o_busy
);

  localparam int NBYTES = NB_DATA / NB_BYTE;
  localparam int NB_CNT = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [NB_CNT-1:0] CNT_LAST = NB_CNT'(NBYTES - 1);

  typedef enum logic [2:0] {
    S_DATA1,
    S_DATA2,
    S_OP,
    S_EXEC,
    S_TX_LOAD,
    S_TX_WAIT
  } state_t;

  state_t              state_q, state_d;
  logic [NB_CNT-1:0]   cnt_q, cnt_d, cnt_inc;
  logic [NB_DATA-1:0]  alu_data_1_q, alu_data_1_d;
  logic [NB_DATA-1:0]  alu_data_2_q, alu_data_2_d;
  logic [NB_OP-1:0]    alu_code_q, alu_code_d;
  logic [NB_DATA-1:0]  result_q, result_d;
  logic [NB_BYTE-1:0]  tx_data_q, tx_data_d;
  logic                tx_start_q, tx_start_d;

  assign cnt_inc = cnt_q + NB_CNT'(1);

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    alu_data_1_d = alu_data_1_q;
    alu_data_2_d = alu_data_2_q;
    alu_code_d   = alu_code_q;
    result_d     = result_q;
    tx_data_d    = tx_data_q;
    tx_start_d   = 1'b0;
    case (state_q)
      S_DATA1: begin
        if (i_rx_valid) begin
          alu_data_1_d[cnt_q*NB_BYTE +: NB_BYTE] = i_rx_data;
          if (cnt_q == CNT_LAST) begin
            cnt_d   = '0;
            state_d = S_DATA2;
          end else begin
            cnt_d = cnt_inc;
          end
        end
      end
      S_DATA2: begin
        if (i_rx_valid) begin
          alu_data_2_d[cnt_q*NB_BYTE +: NB_BYTE] = i_rx_data;
          if (cnt_q == CNT_LAST) begin
            cnt_d   = '0;
            state_d = S_OP;
          end else begin
            cnt_d = cnt_inc;
          end
        end
      end
      S_OP: begin
        if (i_rx_valid) begin
          alu_code_d = i_rx_data[NB_OP-1:0];
          state_d    = S_EXEC;
        end
      end
      // Lane 0 is loaded straight from the ALU so the first start lines up with the capture edge.
      S_EXEC: begin
        result_d   = i_alu_result;
        cnt_d      = '0;
        tx_data_d  = i_alu_result[NB_BYTE-1:0];
        tx_start_d = 1'b1;
        state_d    = S_TX_LOAD;
      end
      S_TX_LOAD: begin
        state_d = S_TX_WAIT;
      end
      S_TX_WAIT: begin
        if (i_tx_done) begin
          if (cnt_q == CNT_LAST) begin
            cnt_d   = '0;
            state_d = S_DATA1;
          end else begin
            cnt_d      = cnt_inc;
            tx_data_d  = result_q[cnt_inc*NB_BYTE +: NB_BYTE];
            tx_start_d = 1'b1;
            state_d    = S_TX_LOAD;
          end
        end
      end
      default: state_d = S_DATA1;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q      <= S_DATA1;
      cnt_q        <= '0;
      alu_data_1_q <= '0;
      alu_data_2_q <= '0;
      alu_code_q   <= '0;
      result_q     <= '0;
      tx_data_q    <= '0;
      tx_start_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      alu_data_1_q <= alu_data_1_d;
      alu_data_2_q <= alu_data_2_d;
      alu_code_q   <= alu_code_d;
      result_q     <= result_d;
      tx_data_q    <= tx_data_d;
      tx_start_q   <= tx_start_d;
    end
  end

  assign o_tx_data    = tx_data_q;
  assign o_tx_start   = tx_start_q;
  assign o_alu_data_1 = alu_data_1_q;
  assign o_alu_data_2 = alu_data_2_q;
  assign o_alu_code   = alu_code_q;
  assign o_busy       = (state_q == S_EXEC) || (state_q == S_TX_LOAD) || (state_q == S_TX_WAIT);

endmodule

// File: tb/tb_ex_alu_uart_ctrl.sv
// Bench for ex_alu_uart_ctrl: frame-level reference model checked every cycle, plus directed literal expectations.
module tb_ex_alu_uart_ctrl;
  localparam int NBYTES = 4;

  logic        clk = 1'b0;
  logic        i_reset = 1'b1;
  logic [7:0]  i_rx_data = 8'h00;
  logic        i_rx_valid = 1'b0;
  logic        i_tx_done = 1'b0;
  logic [7:0]  o_tx_data;
  logic        o_tx_start;
  logic [31:0] o_alu_data_1, o_alu_data_2;
  logic [5:0]  o_alu_code;
  logic [31:0] i_alu_result;
  logic        o_busy;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  ex_alu_uart_ctrl #(.NB_DATA(32), .NB_OP(6), .NB_BYTE(8)) dut (
    .i_clk(clk), .i_reset(i_reset), .i_rx_data(i_rx_data), .i_rx_valid(i_rx_valid),
    .i_tx_done(i_tx_done), .o_tx_data(o_tx_data), .o_tx_start(o_tx_start),
    .o_alu_data_1(o_alu_data_1), .o_alu_data_2(o_alu_data_2), .o_alu_code(o_alu_code),
    .i_alu_result(i_alu_result), .o_busy(o_busy)
  );

  function automatic logic [31:0] alu(input logic [31:0] a, input logic [31:0] b, input logic [5:0] c);
    case (c)
      6'h20:   return a + b;
      6'h22:   return a - b;
      6'h24:   return a & b;
      6'h25:   return a | b;
      6'h26:   return a ^ b;
      6'h27:   return ~(a | b);
      default: return 32'h0;
    endcase
  endfunction

  assign i_alu_result = alu(o_alu_data_1, o_alu_data_2, o_alu_code);

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: frame-level view of what the block must present each cycle.
  logic [31:0] m_op1 = '0, m_op2 = '0, m_res;
  logic [5:0]  m_code = '0;
  logic [7:0]  m_txb [NBYTES];
  logic [7:0]  m_cur = '0;
  int          m_nrx = 0, m_sent = 0;
  bit          m_busy = 0, m_exec = 0, m_start = 0, m_on = 0, start_nx;
  logic [7:0]  cap [$];

  always @(negedge clk) begin
    if (m_on) begin
      chk("op1", o_alu_data_1, m_op1);
      chk("op2", o_alu_data_2, m_op2);
      chk("code", 32'(o_alu_code), 32'(m_code));
      chk("busy", 32'(o_busy), 32'(m_busy));
      chk("tx_start", 32'(o_tx_start), 32'(m_start));
      chk("tx_data", 32'(o_tx_data), 32'(m_cur));
    end
    if (o_tx_start === 1'b1) cap.push_back(o_tx_data);
    if (i_reset) begin
      m_op1 = '0; m_op2 = '0; m_code = '0; m_cur = '0;
      m_nrx = 0; m_sent = 0; m_busy = 0; m_exec = 0; m_start = 0; m_on = 1;
    end else begin
      start_nx = 0;
      if (m_exec) begin
        m_res = alu(m_op1, m_op2, m_code);
        for (int k = 0; k < NBYTES; k++) m_txb[k] = m_res[8*k +: 8];
        m_exec = 0; m_cur = m_txb[0]; m_sent = 1; start_nx = 1;
      end else if (m_start) begin
        start_nx = 0;
      end else if (m_busy) begin
        if (i_tx_done) begin
          if (m_sent == NBYTES) m_busy = 0;
          else begin
            m_cur = m_txb[m_sent]; m_sent++; start_nx = 1;
          end
        end
      end else if (i_rx_valid) begin
        if (m_nrx < NBYTES) m_op1[8*m_nrx +: 8] = i_rx_data;
        else if (m_nrx < 2*NBYTES) m_op2[8*(m_nrx-NBYTES) +: 8] = i_rx_data;
        else begin
          m_code = i_rx_data[5:0]; m_busy = 1; m_exec = 1;
        end
        m_nrx = (m_nrx == 2*NBYTES) ? 0 : m_nrx + 1;
      end
      m_start = start_nx;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    i_rx_data = b; i_rx_valid = 1'b1;
    tick();
    i_rx_valid = 1'b0;
  endtask

  task automatic send_frame(input logic [31:0] a, input logic [31:0] b, input logic [7:0] c);
    for (int k = 0; k < NBYTES; k++) send_byte(a[8*k +: 8]);
    for (int k = 0; k < NBYTES; k++) send_byte(b[8*k +: 8]);
    send_byte(c);
  endtask

  task automatic wait_start(output bit ok);
    ok = 0;
    for (int i = 0; i < 300; i++) begin
      if (o_tx_start === 1'b1) begin
        ok = 1;
        break;
      end
      tick();
    end
    if (!ok) begin
      n_tests++; n_fail++;
      $display("FAIL wait_start: no o_tx_start within 300 cycles at %0t", $time);
    end
  endtask

  // Answer each start with tx_done d cycles later; early=1 also pulses done in the start cycle.
  task automatic run_tx(input int d, input bit early, input bit inject);
    bit ok;
    for (int k = 0; k < NBYTES; k++) begin
      wait_start(ok);
      if (!ok) return;
      if (early) begin
        i_tx_done = 1'b1; tick(); i_tx_done = 1'b0;
        repeat (d - 1) tick();
      end else if (inject && k == 0) begin
        tick(); send_byte(8'hAA); send_byte(8'hBB);
        repeat (d - 3) tick();
      end else begin
        repeat (d) tick();
      end
      i_tx_done = 1'b1; tick(); i_tx_done = 1'b0;
    end
  endtask

  task automatic check_frame(input string nm, input logic [31:0] exp);
    repeat (5) tick();
    chk({nm, " nstart"}, 32'(cap.size()), 32'(NBYTES));
    if (cap.size() == NBYTES) chk({nm, " bytes"}, {cap[3], cap[2], cap[1], cap[0]}, exp);
    cap.delete();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    repeat (2) tick();
    i_reset = 1'b0;
    chk("reset op1", o_alu_data_1, 32'h0);
    chk("reset busy", 32'(o_busy), 32'h0);
    chk("reset tx_data", 32'(o_tx_data), 32'h0);
    cap.delete();

    send_frame(32'h5, 32'h3, 8'h20);
    run_tx(10, 0, 0);
    chk("add busy after done", 32'(o_busy), 32'h0);
    chk("add code", 32'(o_alu_code), 32'h20);
    check_frame("add", 32'h0000_0008);

    send_frame(32'h3, 32'h5, 8'h22);
    run_tx(3, 0, 0);
    check_frame("sub", 32'hFFFF_FFFE);

    send_frame(32'h0, 32'h0, 8'h27);
    run_tx(2, 0, 0);
    check_frame("nor", 32'hFFFF_FFFF);

    send_frame(32'h7, 32'h9, 8'hE0);
    chk("mask code", 32'(o_alu_code), 32'h20);
    run_tx(6, 0, 1);
    chk("drop op1", o_alu_data_1, 32'h7);
    chk("drop code", 32'(o_alu_code), 32'h20);
    check_frame("masked add", 32'h0000_0010);

    send_frame(32'h7, 32'h9, 8'h3F);
    run_tx(2, 0, 0);
    chk("undef idle", 32'(o_busy), 32'h0);
    check_frame("undef", 32'h0000_0000);

    send_frame(32'h1, 32'h1, 8'h24);
    run_tx(4, 0, 0);
    check_frame("and", 32'h0000_0001);

    send_byte(8'h11); send_byte(8'h22);
    i_reset = 1'b1; tick(); i_reset = 1'b0;
    chk("rst op1", o_alu_data_1, 32'h0);
    chk("rst op2", o_alu_data_2, 32'h0);
    chk("rst code", 32'(o_alu_code), 32'h0);
    chk("rst start", 32'(o_tx_start), 32'h0);

    send_frame(32'h1234_5678, 32'h1111_1111, 8'h20);
    run_tx(1, 0, 0);
    check_frame("fresh add", 32'h2345_6789);

    send_frame(32'h100, 32'h1, 8'h22);
    run_tx(200, 1, 0);
    check_frame("slow sub", 32'h0000_00FF);

    send_frame(32'hA, 32'hB, 8'h25);
    wait_start(ok);
    repeat (2) tick();
    i_reset = 1'b1; tick(); i_reset = 1'b0;
    repeat (30) tick();
    chk("tx reset nstart", 32'(cap.size()), 32'h1);
    chk("tx reset busy", 32'(o_busy), 32'h0);
    cap.delete();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
